mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multi-cycle successor to the single-cycle MIPS decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives datapath enables and mux selects per state.
- Waits on instruction and data memory ready handshakes, flags illegal opcodes, and counts retired instructions.
- Sits between the IR/PC registers and the GRF/ALU/DM datapath.

Parameters:
- CNT_W, 32: width of the retired-instruction counter.
- FAST_BRANCH, 0: 1 resolves beq in DECODE (2-cycle branch); 0 resolves it in EXEC.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- IR  in  32  current instruction; stable from the cycle after IR_WE.
- zero  in  1  ALU/comparator equal flag; valid in the beq resolve state.
- im_ready  in  1  instruction memory data valid.
- dm_ready  in  1  data memory access complete.
- PC_WE  out  1  PC write enable.
- IR_WE  out  1  IR write enable.
- NPCsel  out  2  next-PC select: 0 PC+4, 1 branch, 2 j/jal target, 3 rs (jr).
- ExtOp  out  2  immediate extend: 0 sign, 1 zero, 2 load-upper (imm<<16).
- ALUasel  out  2  ALU A select: 0 rs.
- ALUbsel  out  2  ALU B select: 0 rt, 1 extended imm.
- ALUOp  out  4  ALU op: 0000 add, 0001 sub, 0011 or.
- DM_RE  out  1  data memory read enable.
- DM_WE  out  1  data memory write enable.
- A3sel  out  2  GRF write address: 0 rd, 1 rt, 2 $31.
- WDsel  out  2  GRF write data: 0 ALU, 1 DM, 2 PC.
- GRF_WE  out  1  register file write enable.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- instret  out  CNT_W  retired-instruction count.
- state  out  3  debug state: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB.

Behaviour:
- Reset (async):
  - state goes to FETCH immediately.
  - instret is 0.
  - All enables (PC_WE, IR_WE, DM_RE, DM_WE, GRF_WE, illegal) deassert immediately.
  - All selects are 0.
- Outputs are never X. Every select not listed for a state is driven 0; every enable not listed is driven 0.
- Selects for the decoded instruction are held constant from DECODE through the last state of that instruction.
- Decoded set:
  - R-type (op 000000): addu (func 100001), subu (100011), jr (001000).
  - I-type: ori (001101), lui (001111), lw (100011), sw (101011), beq (000100).
  - J-type: j (000010), jal (000011).
  - Anything else is illegal.
- FETCH:
  - IR_WE = PC_WE = im_ready, with NPCsel=0.
  - Stays in FETCH while im_ready=0; goes to DECODE when im_ready=1.
- DECODE:
  - j: PC_WE=1, NPCsel=2, then FETCH.
  - jal: PC_WE=1, NPCsel=2, GRF_WE=1, A3sel=2, WDsel=2 (PC already holds old PC+4), then FETCH.
  - jr: PC_WE=1, NPCsel=3, then FETCH.
  - beq with FAST_BRANCH=1: PC_WE=zero, NPCsel=1, then FETCH.
  - Illegal: illegal=1, no writes, instret unchanged, then FETCH.
  - All other instructions: go to EXEC.
- EXEC:
  - addu/subu: ALUbsel=0, ALUOp 0000/0001, then WB.
  - ori: ExtOp=1, ALUbsel=1, ALUOp=0011, then WB.
  - lui: ExtOp=2, ALUbsel=1, ALUOp=0000, then WB.
  - lw/sw: ExtOp=0, ALUbsel=1, ALUOp=0000, then MEM.
  - beq (FAST_BRANCH=0): ALUOp=0001, PC_WE=zero, NPCsel=1, then FETCH.
- MEM:
  - lw: DM_RE=1 while waiting.
  - sw: DM_WE=1 while waiting; the store commits in the cycle dm_ready=1.
  - Stays in MEM while dm_ready=0.
  - On dm_ready=1: lw goes to WB; sw goes to FETCH.
- WB: GRF_WE=1, then FETCH.
  - addu/subu: A3sel=0, WDsel=0.
  - ori/lui: A3sel=1, WDsel=0.
  - lw: A3sel=1, WDsel=1.
- Latency with ready held high, in cycles:
  - j/jal/jr: 2.
  - beq: 3, or 2 with FAST_BRANCH.
  - addu/subu/ori/lui/sw: 4.
  - lw: 5.
  - Each ready=0 cycle adds one.
- instret:
  - Increments by 1 on the final state-cycle of each legal instruction (the cycle returning to FETCH).
  - Wraps modulo 2^CNT_W.
  - Not-taken beq still retires.
- Reset asserted mid-MEM aborts the access: DM_WE drops asynchronously and no GRF write occurs.
- State encodings 5–7 are unreachable; if entered they recover to FETCH on the next edge with all enables 0.

Test Plan:
- Reset, then ori $1,$0,0x1234 with ready=1 → FETCH,DECODE,EXEC,WB. WB has GRF_WE=1, A3sel=1, ExtOp=1, ALUOp=0011. instret=1 after 4 cycles.
- lw with dm_ready low for 3 MEM cycles → DM_RE=1 for 4 cycles, then WB with WDsel=1, A3sel=1. Total 8 cycles. No GRF_WE before WB.
- beq, zero=1 then zero=0, run with FAST_BRANCH=0 and with FAST_BRANCH=1 → PC_WE pulses only when taken, NPCsel=1. Branch takes 3 cycles (FAST_BRANCH=0) or 2 cycles (FAST_BRANCH=1). instret increments both times.
- jal → 2 cycles. DECODE has PC_WE=1, NPCsel=2, GRF_WE=1, A3sel=2, WDsel=2.
- IR=0xFC000000 → illegal pulses for 1 cycle in DECODE, no write enables, instret unchanged, next state FETCH.
- CNT_W=4, retire 17 addu → instret=1 (wrap). Assert reset during sw MEM with dm_ready=0 → DM_WE=0 same cycle, state=0, instret=0.

Source files
------------

// File: rtl/mc_control.sv
// Multi-cycle MIPS control: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives datapath enables and selects, flags illegal opcodes and counts retirements.
module mc_control #(
  parameter int CNT_W       = 32,
  parameter bit FAST_BRANCH = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IR,
  input  logic             zero,
  input  logic             im_ready,
  input  logic             dm_ready,
  output logic             PC_WE,
  output logic             IR_WE,
  output logic [1:0]       NPCsel,
  output logic [1:0]       ExtOp,
  output logic [1:0]       ALUasel,
  output logic [1:0]       ALUbsel,
  output logic [3:0]       ALUOp,
  output logic             DM_RE,
  output logic             DM_WE,
  output logic [1:0]       A3sel,
  output logic [1:0]       WDsel,
  output logic             GRF_WE,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t cur_st, nxt_st;

  logic [5:0] op, func;
  logic       unused_ir;
  assign op        = IR[31:26];
  assign func      = IR[5:0];
  assign unused_ir = ^IR[25:6];

  logic i_addu, i_subu, i_jr, i_ori, i_lui, i_lw, i_sw, i_beq, i_j, i_jal, legal;

  always_comb begin
    i_addu = (op == 6'b000000) && (func == 6'b100001);
    i_subu = (op == 6'b000000) && (func == 6'b100011);
    i_jr   = (op == 6'b000000) && (func == 6'b001000);
    i_ori  = (op == 6'b001101);
    i_lui  = (op == 6'b001111);
    i_lw   = (op == 6'b100011);
    i_sw   = (op == 6'b101011);
    i_beq  = (op == 6'b000100);
    i_j    = (op == 6'b000010);
    i_jal  = (op == 6'b000011);
    legal  = i_addu | i_subu | i_jr | i_ori | i_lui | i_lw | i_sw | i_beq | i_j | i_jal;
  end

  // Per-instruction selects; an illegal word decodes to all zeros.
  logic [1:0] dec_npc, dec_ext, dec_bsel, dec_a3, dec_wd;
  logic [3:0] dec_aluop;

  always_comb begin
    dec_npc   = 2'd0;
    dec_ext   = 2'd0;
    dec_bsel  = 2'd0;
    dec_aluop = 4'b0000;
    dec_a3    = 2'd0;
    dec_wd    = 2'd0;
    if (i_beq)         dec_npc = 2'd1;
    if (i_j | i_jal)   dec_npc = 2'd2;
    if (i_jr)          dec_npc = 2'd3;
    if (i_ori)         dec_ext = 2'd1;
    if (i_lui)         dec_ext = 2'd2;
    if (i_ori | i_lui | i_lw | i_sw) dec_bsel = 2'd1;
    if (i_subu | i_beq) dec_aluop = 4'b0001;
    if (i_ori)         dec_aluop = 4'b0011;
    if (i_ori | i_lui | i_lw) dec_a3 = 2'd1;
    if (i_jal)         dec_a3 = 2'd2;
    if (i_lw)          dec_wd = 2'd1;
    if (i_jal)         dec_wd = 2'd2;
  end

  logic pc_we, ir_we, dm_re, dm_we, grf_we, ill, hold_sel, done;

  always_comb begin
    nxt_st   = cur_st;
    pc_we    = 1'b0;
    ir_we    = 1'b0;
    dm_re    = 1'b0;
    dm_we    = 1'b0;
    grf_we   = 1'b0;
    ill      = 1'b0;
    hold_sel = 1'b0;
    done     = 1'b0;
    case (cur_st)
      S_FETCH: begin
        pc_we = im_ready;
        ir_we = im_ready;
        if (im_ready) nxt_st = S_DECODE;
      end
      S_DECODE: begin
        hold_sel = 1'b1;
        if (!legal) begin
          ill    = 1'b1;
          nxt_st = S_FETCH;
        end else if (i_j | i_jr) begin
          pc_we  = 1'b1;
          done   = 1'b1;
          nxt_st = S_FETCH;
        end else if (i_jal) begin
          pc_we  = 1'b1;
          grf_we = 1'b1;
          done   = 1'b1;
          nxt_st = S_FETCH;
        end else if (i_beq && FAST_BRANCH) begin
          pc_we  = zero;
          done   = 1'b1;
          nxt_st = S_FETCH;
        end else begin
          nxt_st = S_EXEC;
        end
      end
      S_EXEC: begin
        hold_sel = 1'b1;
        if (i_beq) begin
          pc_we  = zero;
          done   = 1'b1;
          nxt_st = S_FETCH;
        end else if (i_lw | i_sw) begin
          nxt_st = S_MEM;
        end else begin
          nxt_st = S_WB;
        end
      end
      S_MEM: begin
        hold_sel = 1'b1;
        dm_re    = i_lw;
        dm_we    = i_sw;
        if (dm_ready) begin
          nxt_st = i_lw ? S_WB : S_FETCH;
          done   = i_sw;
        end
      end
      S_WB: begin
        hold_sel = 1'b1;
        grf_we   = 1'b1;
        done     = 1'b1;
        nxt_st   = S_FETCH;
      end
      default: nxt_st = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_st  <= S_FETCH;
      instret <= '0;
    end else begin
      cur_st <= nxt_st;
      if (done) instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Enables are gated by reset so an in-flight access aborts without waiting for an edge.
  assign PC_WE   = pc_we  & ~reset;
  assign IR_WE   = ir_we  & ~reset;
  assign DM_RE   = dm_re  & ~reset;
  assign DM_WE   = dm_we  & ~reset;
  assign GRF_WE  = grf_we & ~reset;
  assign illegal = ill    & ~reset;

  assign NPCsel  = hold_sel ? dec_npc   : 2'd0;
  assign ExtOp   = hold_sel ? dec_ext   : 2'd0;
  assign ALUasel = 2'd0;
  assign ALUbsel = hold_sel ? dec_bsel  : 2'd0;
  assign ALUOp   = hold_sel ? dec_aluop : 4'b0000;
  assign A3sel   = hold_sel ? dec_a3    : 2'd0;
  assign WDsel   = hold_sel ? dec_wd    : 2'd0;
  assign state   = cur_st;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: two instances (slow branch / 32-bit count, fast branch / 4-bit count)
// driven by directed and random instruction streams against a per-instruction trace model.
module tb_mc_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] ir;
  logic        zr, imr, dmr, sel1;
  logic        im0, dm0, im1, dm1;
  assign im0 = imr & ~sel1;
  assign dm0 = dmr & ~sel1;
  assign im1 = imr & sel1;
  assign dm1 = dmr & sel1;

  logic        pc_we0, ir_we0, dm_re0, dm_we0, grf_we0, ill0;
  logic [1:0]  npc0, ext0, asel0, bsel0, a3_0, wd0;
  logic [3:0]  op0;
  logic [31:0] cnt0;
  logic [2:0]  st0;
  logic        pc_we1, ir_we1, dm_re1, dm_we1, grf_we1, ill1;
  logic [1:0]  npc1, ext1, asel1, bsel1, a3_1, wd1;
  logic [3:0]  op1;
  logic [3:0]  cnt1;
  logic [2:0]  st1;

  mc_control #(.CNT_W(32), .FAST_BRANCH(1'b0)) dut0 (
    .clk(clk), .reset(reset), .IR(ir), .zero(zr), .im_ready(im0), .dm_ready(dm0),
    .PC_WE(pc_we0), .IR_WE(ir_we0), .NPCsel(npc0), .ExtOp(ext0), .ALUasel(asel0),
    .ALUbsel(bsel0), .ALUOp(op0), .DM_RE(dm_re0), .DM_WE(dm_we0), .A3sel(a3_0),
    .WDsel(wd0), .GRF_WE(grf_we0), .illegal(ill0), .instret(cnt0), .state(st0)
  );

  mc_control #(.CNT_W(4), .FAST_BRANCH(1'b1)) dut1 (
    .clk(clk), .reset(reset), .IR(ir), .zero(zr), .im_ready(im1), .dm_ready(dm1),
    .PC_WE(pc_we1), .IR_WE(ir_we1), .NPCsel(npc1), .ExtOp(ext1), .ALUasel(asel1),
    .ALUbsel(bsel1), .ALUOp(op1), .DM_RE(dm_re1), .DM_WE(dm_we1), .A3sel(a3_1),
    .WDsel(wd1), .GRF_WE(grf_we1), .illegal(ill1), .instret(cnt1), .state(st1)
  );

  // Observed view of whichever instance is under test: en = {PC,IR,DM_RE,DM_WE,GRF,illegal}.
  logic [5:0]  o_en;
  logic [15:0] o_sel;
  logic [2:0]  o_st;
  logic [31:0] o_cnt;
  always_comb begin
    if (sel1) begin
      o_en  = {pc_we1, ir_we1, dm_re1, dm_we1, grf_we1, ill1};
      o_sel = {npc1, ext1, asel1, bsel1, op1, a3_1, wd1};
      o_st  = st1;
      o_cnt = {28'd0, cnt1};
    end else begin
      o_en  = {pc_we0, ir_we0, dm_re0, dm_we0, grf_we0, ill0};
      o_sel = {npc0, ext0, asel0, bsel0, op0, a3_0, wd0};
      o_st  = st0;
      o_cnt = cnt0;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  int unsigned exp_cnt [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  typedef enum int {C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL} cls_t;

  function automatic cls_t classify(input logic [31:0] w);
    logic [5:0] o, f;
    o = w[31:26];
    f = w[5:0];
    case (o)
      6'b000000: begin
        if (f == 6'b100001)      return C_ADDU;
        else if (f == 6'b100011) return C_SUBU;
        else if (f == 6'b001000) return C_JR;
        else                     return C_ILL;
      end
      6'b001101: return C_ORI;
      6'b001111: return C_LUI;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b000010: return C_J;
      6'b000011: return C_JAL;
      default:   return C_ILL;
    endcase
  endfunction

  function automatic logic [15:0] pk(input logic [1:0] npc, input logic [1:0] ext,
                                     input logic [1:0] bsel, input logic [3:0] aop,
                                     input logic [1:0] a3, input logic [1:0] wd);
    return {npc, ext, 2'd0, bsel, aop, a3, wd};
  endfunction

  function automatic logic [15:0] exp_sel(input cls_t k);
    case (k)
      C_ADDU:  return pk(0, 0, 0, 4'b0000, 0, 0);
      C_SUBU:  return pk(0, 0, 0, 4'b0001, 0, 0);
      C_JR:    return pk(3, 0, 0, 4'b0000, 0, 0);
      C_ORI:   return pk(0, 1, 1, 4'b0011, 1, 0);
      C_LUI:   return pk(0, 2, 1, 4'b0000, 1, 0);
      C_LW:    return pk(0, 0, 1, 4'b0000, 1, 1);
      C_SW:    return pk(0, 0, 1, 4'b0000, 0, 0);
      C_BEQ:   return pk(1, 0, 0, 4'b0001, 0, 0);
      C_J:     return pk(2, 0, 0, 4'b0000, 0, 0);
      C_JAL:   return pk(2, 0, 0, 4'b0000, 2, 2);
      default: return 16'd0;
    endcase
  endfunction

  typedef struct packed {
    logic [2:0] st;
    logic [5:0] en;
    logic       im;
    logic       dm;
    logic       show;
  } cyc_t;

  function automatic cyc_t mk(input logic [2:0] st, input logic [5:0] en,
                              input logic im, input logic dm, input logic show);
    cyc_t c;
    c.st = st; c.en = en; c.im = im; c.dm = dm; c.show = show;
    return c;
  endfunction

  // Expected cycle trace of one instruction, then drive and compare cycle by cycle.
  task automatic run_instr(input logic [31:0] w, input int fw, input int mw, input logic z);
    cyc_t q[$];
    cls_t k;
    logic done;
    logic [5:0] men;
    k = classify(w);
    for (int i = 0; i < fw; i++) q.push_back(mk(3'd0, 6'b000000, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(3'd0, 6'b110000, 1'b1, 1'b0, 1'b0));
    done = 1'b1;
    case (k)
      C_J, C_JR: q.push_back(mk(3'd1, 6'b100000, 1'b0, 1'b0, 1'b1));
      C_JAL:     q.push_back(mk(3'd1, 6'b100010, 1'b0, 1'b0, 1'b1));
      C_ILL:     q.push_back(mk(3'd1, 6'b000001, 1'b0, 1'b0, 1'b1));
      C_BEQ: begin
        if (sel1) q.push_back(mk(3'd1, {z, 5'b0}, 1'b0, 1'b0, 1'b1));
        else begin
          q.push_back(mk(3'd1, 6'b000000, 1'b0, 1'b0, 1'b1));
          q.push_back(mk(3'd2, {z, 5'b0}, 1'b0, 1'b0, 1'b1));
        end
      end
      default: begin
        q.push_back(mk(3'd1, 6'b000000, 1'b0, 1'b0, 1'b1));
        q.push_back(mk(3'd2, 6'b000000, 1'b0, 1'b0, 1'b1));
        done = 1'b0;
      end
    endcase
    if (!done) begin
      if (k == C_LW || k == C_SW) begin
        men = (k == C_LW) ? 6'b001000 : 6'b000100;
        for (int i = 0; i < mw; i++) q.push_back(mk(3'd3, men, 1'b0, 1'b0, 1'b1));
        q.push_back(mk(3'd3, men, 1'b0, 1'b1, 1'b1));
      end
      if (k != C_SW) q.push_back(mk(3'd4, 6'b000010, 1'b0, 1'b0, 1'b1));
    end

    for (int i = 0; i < q.size(); i++) begin
      ir  = (q[i].st == 3'd0) ? 32'($urandom) : w;
      imr = q[i].im;
      dmr = q[i].dm;
      zr  = (k == C_BEQ) ? z : 1'($urandom);
      @(negedge clk);
      chk($sformatf("state %h c%0d", w, i), {29'd0, o_st}, {29'd0, q[i].st});
      chk($sformatf("enables %h c%0d", w, i), {26'd0, o_en}, {26'd0, q[i].en});
      chk($sformatf("selects %h c%0d", w, i), {16'd0, o_sel},
          {16'd0, q[i].show ? exp_sel(k) : 16'd0});
      @(posedge clk);
      #1;
    end
    imr = 1'b0;
    dmr = 1'b0;
    if (k != C_ILL) exp_cnt[sel1]++;
    chk($sformatf("instret %h", w), o_cnt, sel1 ? (exp_cnt[1] & 32'hF) : exp_cnt[0]);
    chk($sformatf("back_fetch %h", w), {29'd0, o_st}, 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int pick;
    w    = $urandom;
    pick = $urandom_range(0, 10);
    case (pick)
      0: begin w[31:26] = 6'b000000; w[5:0] = 6'b100001; end
      1: begin w[31:26] = 6'b000000; w[5:0] = 6'b100011; end
      2: begin w[31:26] = 6'b000000; w[5:0] = 6'b001000; end
      3: w[31:26] = 6'b001101;
      4: w[31:26] = 6'b001111;
      5: w[31:26] = 6'b100011;
      6: w[31:26] = 6'b101011;
      7: w[31:26] = 6'b000100;
      8: w[31:26] = 6'b000010;
      9: w[31:26] = 6'b000011;
      default: begin
        for (int t = 0; t < 64 && classify(w) != C_ILL; t++) w = $urandom;
        if (classify(w) != C_ILL) w = 32'hFC000000;
      end
    endcase
    return w;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, " state"}, {29'd0, o_st}, 32'd0);
    chk({tag, " enables"}, {26'd0, o_en}, 32'd0);
    chk({tag, " selects"}, {16'd0, o_sel}, 32'd0);
    chk({tag, " instret"}, o_cnt, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imr   = 1'b1;
    @(negedge clk);
    sel1 = 1'b0; #1; check_reset_state("rst0");
    sel1 = 1'b1; #1; check_reset_state("rst1");
    imr = 1'b0;
    reset = 1'b0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; ir = 32'd0; zr = 1'b0; imr = 1'b0; dmr = 1'b0; sel1 = 1'b0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    #2;
    do_reset();

    sel1 = 1'b0;
    run_instr(32'h34011234, 0, 0, 1'b0);   // ori $1,$0,0x1234
    run_instr(32'h8C010000, 0, 3, 1'b0);   // lw, three stalled MEM cycles
    run_instr(32'h10000004, 0, 0, 1'b1);   // beq taken
    run_instr(32'h10000004, 0, 0, 1'b0);   // beq not taken
    run_instr(32'h0C000010, 0, 0, 1'b0);   // jal
    run_instr(32'hFC000000, 0, 0, 1'b0);   // illegal
    run_instr(32'h00221821, 2, 0, 1'b0);   // addu after fetch stall
    sel1 = 1'b1;
    run_instr(32'h10000004, 0, 0, 1'b1);
    run_instr(32'h10000004, 0, 0, 1'b0);

    for (int n = 0; n < 160; n++) begin
      sel1 = n[0];
      run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
    end

    do_reset();
    sel1 = 1'b1;
    for (int n = 0; n < 17; n++) run_instr(32'h00221821, 0, 0, 1'b0);
    chk("wrap17", o_cnt, 32'd1);

    // sw stalled in MEM, then reset mid-cycle
    ir = 32'hAC010004; imr = 1'b1; dmr = 1'b0;
    @(posedge clk); #1;
    imr = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("sw_mem state", {29'd0, o_st}, 32'd3);
    chk("sw_mem enables", {26'd0, o_en}, 32'h4);
    #2 reset = 1'b1;
    #1;
    check_reset_state("mid_mem");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst instret", o_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
